// File: rtl/ace_desc_alloc_sched.sv
// Descriptor allocation scheduler: round-robin requester arbitration, lowest free enabled slot,
// valid/ready offer channel, busy/free-count status and a checked release port.
module ace_desc_alloc_sched #(
  parameter int MAX_DESC = 16,
  parameter int NUM_REQ = 4,
  localparam int DESC_IDX_WIDTH = $clog2(MAX_DESC),
  localparam int REQ_IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [MAX_DESC-1:0]       desc_en,
  output logic                      alloc_vld,
  input  logic                      alloc_rdy,
  output logic [DESC_IDX_WIDTH-1:0] alloc_idx,
  output logic [NUM_REQ-1:0]        alloc_gnt,
  input  logic                      free_vld,
  input  logic [DESC_IDX_WIDTH-1:0] free_idx,
  output logic [MAX_DESC-1:0]       busy,
  output logic [DESC_IDX_WIDTH:0]   free_cnt,
  output logic                      err_free
);

  localparam int SLOT_SPACE = 1 << DESC_IDX_WIDTH;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                    state, next_state;
  logic                      take, done;
  logic [MAX_DESC-1:0]       avail;
  logic [DESC_IDX_WIDTH-1:0] pick;
  logic [DESC_IDX_WIDTH:0]   avail_cnt;
  logic [REQ_IDX_WIDTH-1:0]  rr_ptr, win, gnt_idx, next_ptr;
  logic [NUM_REQ-1:0]        gnt_oh;
  logic [SLOT_SPACE-1:0]     busy_ext;
  logic                      free_ok;
  logic [MAX_DESC-1:0]       busy_nxt;

  assign avail = ~busy & desc_en;

  always_comb begin
    pick = '0;
    for (int i = MAX_DESC - 1; i >= 0; i--) begin
      if (avail[i]) pick = DESC_IDX_WIDTH'(i);
    end
  end

  always_comb begin
    avail_cnt = '0;
    for (int i = 0; i < MAX_DESC; i++) begin
      avail_cnt = avail_cnt + {{DESC_IDX_WIDTH{1'b0}}, avail[i]};
    end
  end

  // First requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_vld[(int'(rr_ptr) + i) % NUM_REQ]) win = REQ_IDX_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
    end
  end

  always_comb begin
    gnt_oh = '0;
    gnt_oh[win] = 1'b1;
  end

  assign next_ptr = (gnt_idx == REQ_IDX_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Slots beyond MAX_DESC read as not busy, so such releases fall out as illegal.
  assign busy_ext = SLOT_SPACE'(busy);
  assign free_ok  = free_vld && busy_ext[free_idx] && !(state == OFFER && free_idx == alloc_idx);

  always_comb begin
    busy_nxt = busy;
    if (take) busy_nxt[pick] = 1'b1;
    if (free_ok) busy_nxt[free_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (|req_vld && |avail) begin
          take       = 1'b1;
          next_state = OFFER;
        end
      end
      OFFER: begin
        if (alloc_rdy) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_vld <= 1'b0;
      alloc_idx <= '0;
      alloc_gnt <= '0;
      gnt_idx   <= '0;
      rr_ptr    <= '0;
      busy      <= '0;
      free_cnt  <= '0;
      err_free  <= 1'b0;
    end else begin
      if (take) begin
        alloc_vld <= 1'b1;
        alloc_idx <= pick;
        alloc_gnt <= gnt_oh;
        gnt_idx   <= win;
      end else if (done) begin
        alloc_vld <= 1'b0;
        alloc_gnt <= '0;
        rr_ptr    <= next_ptr;
      end
      busy     <= busy_nxt;
      free_cnt <= avail_cnt;
      if (free_vld && !free_ok) err_free <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ace_desc_alloc_sched.sv
// Self-checking bench for ace_desc_alloc_sched: per-cycle behavioural model compare
// plus directed scenarios with hand-computed expectations.
module tb_ace_desc_alloc_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_vld = '0;
  logic [15:0] desc_en = 16'hFFFF;
  logic        alloc_vld;
  logic        alloc_rdy = 1'b0;
  logic [3:0]  alloc_idx;
  logic [3:0]  alloc_gnt;
  logic        free_vld = 1'b0;
  logic [3:0]  free_idx = '0;
  logic [15:0] busy;
  logic [4:0]  free_cnt;
  logic        err_free;

  int checks = 0;
  int errors = 0;

  ace_desc_alloc_sched #(.MAX_DESC(16), .NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .desc_en(desc_en),
    .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_idx(alloc_idx),
    .alloc_gnt(alloc_gnt), .free_vld(free_vld), .free_idx(free_idx),
    .busy(busy), .free_cnt(free_cnt), .err_free(err_free)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at a negedge and advance to the next negedge.
  task automatic applyStimulus(input logic [3:0] rq, input logic rdy, input logic fv, input logic [3:0] fi);
    req_vld   = rq;
    alloc_rdy = rdy;
    free_vld  = fv;
    free_idx  = fi;
    @(negedge clk);
  endtask

  task automatic doReset(input logic [15:0] en);
    @(negedge clk);
    rst_n = 1'b0;
    desc_en = en;
    req_vld = '0; alloc_rdy = 1'b0; free_vld = 1'b0; free_idx = '0;
    #1;
    checkOutput("rst_vld", 32'(alloc_vld), 0);
    checkOutput("rst_idx", 32'(alloc_idx), 0);
    checkOutput("rst_gnt", 32'(alloc_gnt), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_cnt", 32'(free_cnt), 0);
    checkOutput("rst_err", 32'(err_free), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Behavioural model: a pool of slot flags, an outstanding-offer record and a rotating priority.
  bit m_busy[16];
  bit m_offer, m_err;
  int m_idx, m_win, m_rr, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_offer = 1'b0; m_err = 1'b0;
      m_idx = 0; m_win = 0; m_rr = 0; m_cnt = 0;
    end else begin
      int n_free, slot, who;
      bit legal;
      n_free = 0; slot = -1; who = -1;
      for (int i = 0; i < 16; i++) begin
        if (!m_busy[i] && desc_en[i]) begin
          n_free++;
          if (slot < 0) slot = i;
        end
      end
      legal = free_vld && m_busy[free_idx] && !(m_offer && int'(free_idx) == m_idx);
      if (!m_offer) begin
        for (int j = 0; j < 4; j++) begin
          if (who < 0 && req_vld[(m_rr + j) % 4]) who = (m_rr + j) % 4;
        end
        if (who >= 0 && slot >= 0) begin
          m_offer = 1'b1; m_idx = slot; m_win = who; m_busy[slot] = 1'b1;
        end
      end else if (alloc_rdy) begin
        m_offer = 1'b0;
        m_rr = (m_win + 1) % 4;
      end
      if (legal) m_busy[free_idx] = 1'b0;
      else if (free_vld) m_err = 1'b1;
      m_cnt = n_free;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      logic [15:0] exp_busy;
      for (int i = 0; i < 16; i++) exp_busy[i] = m_busy[i];
      checkOutput("model_vld", 32'(alloc_vld), 32'(m_offer));
      checkOutput("model_busy", 32'(busy), 32'(exp_busy));
      checkOutput("model_cnt", 32'(free_cnt), m_cnt);
      checkOutput("model_err", 32'(err_free), 32'(m_err));
      if (m_offer) begin
        checkOutput("model_idx", 32'(alloc_idx), m_idx);
        checkOutput("model_gnt", 32'(alloc_gnt), 32'(1) << m_win);
      end else begin
        checkOutput("model_gnt_idle", 32'(alloc_gnt), 0);
      end
    end
  end

  logic [3:0] rr_exp [5];

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Single requester
    doReset(16'hFFFF);
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("cnt_after_reset", 32'(free_cnt), 16);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0001, 1'b1, 1'b0, 4'd0);
      checkOutput("single_vld", 32'(alloc_vld), 1);
      checkOutput("single_idx", 32'(alloc_idx), k);
      checkOutput("single_gnt", 32'(alloc_gnt), 4'b0001);
      if (k == 2) checkOutput("single_cnt", 32'(free_cnt), 14);
      if (k < 2) begin
        applyStimulus(4'b0001, 1'b1, 1'b0, 4'd0);
        checkOutput("single_gap", 32'(alloc_vld), 0);
      end
    end
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'd0);

    // Round-robin
    doReset(16'hFFFF);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, 4'd0);
      checkOutput("rr_gnt", 32'(alloc_gnt), 32'(rr_exp[k]));
      checkOutput("rr_idx", 32'(alloc_idx), k);
      applyStimulus(k == 4 ? 4'b0000 : 4'b1111, 1'b1, 1'b0, 4'd0);
    end

    // Exhaustion and recovery
    doReset(16'hFFFF);
    for (int k = 0; k < 32; k++) applyStimulus(4'b0001, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b0001, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b0001, 1'b1, 1'b0, 4'd0);
    checkOutput("full_vld", 32'(alloc_vld), 0);
    checkOutput("full_cnt", 32'(free_cnt), 0);
    checkOutput("full_busy", 32'(busy), 16'hFFFF);
    applyStimulus(4'b0001, 1'b1, 1'b1, 4'd5);
    checkOutput("freed_vld", 32'(alloc_vld), 0);
    checkOutput("freed_busy", 32'(busy), 16'hFFDF);
    applyStimulus(4'b0001, 1'b1, 1'b0, 4'd0);
    checkOutput("refill_vld", 32'(alloc_vld), 1);
    checkOutput("refill_idx", 32'(alloc_idx), 5);
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'd0);

    // Backpressure, plus release of the offered slot
    doReset(16'hFFFF);
    applyStimulus(4'b0010, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b0010, 1'b0, 1'b0, 4'd0);
      checkOutput("bp_vld", 32'(alloc_vld), 1);
      checkOutput("bp_idx", 32'(alloc_idx), 0);
      checkOutput("bp_gnt", 32'(alloc_gnt), 4'b0010);
      checkOutput("bp_busy", 32'(busy), 16'h0001);
    end
    applyStimulus(4'b0010, 1'b0, 1'b1, 4'd0);
    checkOutput("offered_free_err", 32'(err_free), 1);
    checkOutput("offered_free_busy", 32'(busy), 16'h0001);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'd0);
    checkOutput("bp_done", 32'(alloc_vld), 0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'd0);
    checkOutput("bp_next_gnt", 32'(alloc_gnt), 4'b0100);
    checkOutput("bp_next_idx", 32'(alloc_idx), 1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'd0);

    // Release of a slot that is not busy
    doReset(16'hFFFF);
    applyStimulus(4'b0000, 1'b0, 1'b1, 4'd7);
    checkOutput("idle_free_err", 32'(err_free), 1);
    checkOutput("idle_free_busy", 32'(busy), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("err_sticky", 32'(err_free), 1);

    // Masking, then asynchronous reset in the middle of an offer
    doReset(16'h00F0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("mask_cnt", 32'(free_cnt), 4);
    applyStimulus(4'b0001, 1'b0, 1'b0, 4'd0);
    checkOutput("mask_vld", 32'(alloc_vld), 1);
    checkOutput("mask_idx", 32'(alloc_idx), 4);
    applyStimulus(4'b0001, 1'b0, 1'b0, 4'd0);
    doReset(16'hFFFF);
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
